spi_mem_responder: RTL and testbench
====================================

// Module: spi_mem_responder
// PURPOSE
//   SPI mode-0 memory responder (target): the far end of the SPI cache's link. Decodes opcode,
//   24-bit address and data bytes from an oversampled SPI bus and maps them onto a simple
//   synchronous byte-RAM port. Tracks the RESET_EN/RESET power-up sequence the cache sends
//   during its init phase and reports completion on init_done. Used as the bench/FPGA memory model.
// PARAMETERS
//   ADDR_W        16          RAM address width; low ADDR_W bits of the 24-bit SPI address are used
//   DEVICE_ID     24'h0D5D52  value returned MSB-first by READ_ID (0x9F)
//   REQUIRE_INIT  1           1: READ/WRITE ignored (IGNORE state) until init_done=1
// PORTS
//   clk          in   1       system clock; must be >= 8x spi_sclk frequency
//   rst          in   1       reset, synchronous, active-high
//   spi_sclk     in   1       SPI clock, asynchronous to clk
//   spi_cs_n     in   1       chip select, active-low, asynchronous
//   spi_mosi     in   1       controller-to-responder data, asynchronous
//   spi_miso     out  1       responder-to-controller data
//   spi_miso_oe  out  1       MISO drive enable (high only while shifting READ/READ_ID data)
//   mem_addr     out  ADDR_W  RAM byte address
//   mem_re       out  1       RAM read strobe; mem_rdata valid the cycle after
//   mem_rdata    in   8       RAM read data
//   mem_we       out  1       RAM write strobe, one-cycle pulse
//   mem_wdata    out  8       RAM write data
//   init_done    out  1       high once a RESET_EN then RESET transaction pair has completed
//   cmd_err      out  1       one-cycle pulse on unsupported opcode
// BEHAVIOUR
//   - Reset: spi_miso=0, spi_miso_oe=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0,
//     init_done=0, cmd_err=0, state IDLE, RESET_EN arm flag clear.
//   - Inputs pass a 2-FF synchronizer; sclk rise/fall and cs_n rise/fall detected in clk domain.
//     Latency pin->edge event: 3 clk. MOSI sampled on sclk rise, MISO updated on sclk fall, MSB first.
//   - States: IDLE, CMD, ADDR, RD_DATA, WR_DATA, ID_DATA, IGNORE.
//     IDLE --cs fall--> CMD. CMD after 8 bits: 0x03->ADDR(rd), 0x02->ADDR(wr), 0x9F->ID_DATA,
//     0x66/0x99->IGNORE (opcode recorded), other->IGNORE + cmd_err pulse.
//     ADDR after 24 bits: rd->RD_DATA, wr->WR_DATA. Any state --cs rise--> IDLE (highest priority).
//   - 3-bit bit counter, 5-bit counter for ADDR; reset to 0 on entry to each state.
//   - RD_DATA: mem_re pulsed the cycle the 24th address bit is captured; byte loaded into shifter
//     before next sclk fall; bit7 driven on that fall. mem_re for addr+1 issued when bit7 of the
//     current byte is driven; prefetched byte held in a buffer. Address increments per byte and
//     wraps 2^ADDR_W-1 -> 0. Unlimited burst until cs rise.
//   - WR_DATA: after 8th bit sampled, mem_we=1 one cycle with mem_addr/mem_wdata; address
//     increments and wraps as above. Partial byte at cs rise discarded, no write.
//   - ID_DATA: shifts DEVICE_ID bits 23..0, then 0s for further clocks.
//   - Init: a transaction of exactly 8 bits = 0x66 ending with cs rise sets arm flag. The next
//     transaction of exactly 8 bits = 0x99 ending with cs rise and arm set -> init_done=1 (sticky
//     until rst). Any other completed transaction clears arm. 0x99 without arm: no effect.
//   - REQUIRE_INIT=1 and init_done=0: 0x02/0x03 go to IGNORE (no mem_re/mem_we, miso_oe=0, no cmd_err).
//   - spi_miso_oe=1 from first data-bit fall in RD_DATA/ID_DATA until cs rise seen; spi_miso=0 when oe=0.
//   - cs rise mid-byte in any state: counters cleared, no strobes issued afterward.
//   - rst asserted mid-transaction: immediate return to reset values; bus ignored until next cs fall.
// STRUCTURE
//   - Package spi_mem_pkg: opcode localparams (OP_READ 8'h03, OP_WRITE 8'h02, OP_RDID 8'h9F,
//     OP_RSTEN 8'h66, OP_RST 8'h99) and responder state_t enum.
//   - Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, one instance per input.
// TESTING
//   - rst, then 0x66 txn, 0x99 txn -> init_done rises 1 cycle after second cs rise; stays 1.
//   - REQUIRE_INIT=1, no init, WRITE 0x000010 data 0xA5 -> no mem_we pulse, RAM unchanged.
//   - After init: WRITE 0x000010 A5 5A C3 -> mem_we x3 at addr 0x10/0x11/0x12; READ 0x000010
//     3 bytes -> MISO returns A5 5A C3, miso_oe only during data.
//   - READ at 0x00FFFF (ADDR_W=16), 2 bytes -> second byte from addr 0x0000.
//   - READ_ID 0x9F, 24 clocks -> 0x0D5D52; opcode 0xAB -> cmd_err pulse once, miso_oe stays 0.
//   - WRITE with cs rise after 5 data bits -> no mem_we; next 0x66 then 0x05 then 0x99 -> init_done stays 0.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: opcodes and state encoding shared by the SPI memory responder
package spi_mem_pkg;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        ID_DATA,
        IGNORE
    } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with rise/fall pulses taken from the settled stage
module spi_sync_edge (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[1:0], din};
    always_ff @(posedge clk) sync_q <= sync_d;
    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 target mapping READ/WRITE/READ_ID onto a byte-RAM port
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter logic [23:0] DEVICE_ID    = 24'h0D5D52,
    parameter bit          REQUIRE_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              init_done,
    output logic              cmd_err
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;
    spi_sync_edge u_sclk (.clk(clk), .din(spi_sclk), .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_cs   (.clk(clk), .din(spi_cs_n), .level(unused_cs_lvl),   .rise(cs_rise),   .fall(cs_fall));
    spi_sync_edge u_mosi (.clk(clk), .din(spi_mosi), .level(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall));
    state_t              state_q, state_d;
    logic [2:0]          bit_q, bit_d;
    logic [4:0]          addr_cnt_q, addr_cnt_d;
    logic [7:0]          rx_q, rx_d, op_q, op_d, buf_q, buf_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d, addr_q, addr_d;
    logic [23:0]         tx_q, tx_d;
    logic                is_wr_q, is_wr_d, exact_q, exact_d, arm_q, arm_d;
    logic                init_q, init_d, re_q, re_d, we_q, we_d, rd_vld_q, rd_vld_d;
    logic                miso_q, miso_d, oe_q, oe_d, err_q, err_d;
    logic [7:0]          rx_next;
    logic [ADDR_W-1:0]   addr_sh_next;
    logic                locked;
    assign locked = REQUIRE_INIT && !init_q;
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        addr_cnt_d   = addr_cnt_q;
        rx_d         = rx_q;
        op_d         = op_q;
        addr_sh_d    = addr_sh_q;
        tx_d         = tx_q;
        is_wr_d      = is_wr_q;
        exact_d      = exact_q;
        arm_d        = arm_q;
        init_d       = init_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        wdata_d      = wdata_q;
        re_d         = 1'b0;
        we_d         = 1'b0;
        err_d        = 1'b0;
        rd_vld_d     = re_q;
        buf_d        = rd_vld_q ? mem_rdata : buf_q;
        addr_d       = we_q ? addr_q + ADDR_W'(1) : addr_q;
        rx_next      = {rx_q[6:0], mosi};
        addr_sh_next = {addr_sh_q[ADDR_W-2:0], mosi};
        if (state_q != IDLE && cs_rise) begin
            state_d    = IDLE;
            bit_d      = 3'd0;
            addr_cnt_d = 5'd0;
            oe_d       = 1'b0;
            miso_d     = 1'b0;
            arm_d      = exact_q && op_q == OP_RSTEN;
            init_d     = init_q || (exact_q && arm_q && op_q == OP_RST);
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d = CMD;
                    bit_d   = 3'd0;
                    exact_d = 1'b0;
                end
                CMD: if (sclk_rise) begin
                    rx_d  = rx_next;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        op_d       = rx_next;
                        exact_d    = 1'b1;
                        addr_cnt_d = 5'd0;
                        is_wr_d    = rx_next == OP_WRITE;
                        tx_d       = DEVICE_ID;
                        if ((rx_next == OP_READ || rx_next == OP_WRITE) && !locked) state_d = ADDR;
                        else if (rx_next == OP_RDID) state_d = ID_DATA;
                        else begin
                            state_d = IGNORE;
                            err_d   = !(rx_next inside {OP_READ, OP_WRITE, OP_RSTEN, OP_RST});
                        end
                    end
                end
                ADDR: if (sclk_rise) begin
                    exact_d    = 1'b0;
                    addr_sh_d  = addr_sh_next;
                    addr_cnt_d = addr_cnt_q + 5'd1;
                    if (addr_cnt_q == 5'd23) begin
                        addr_d  = addr_sh_next;
                        re_d    = !is_wr_q;
                        bit_d   = 3'd0;
                        state_d = is_wr_q ? WR_DATA : RD_DATA;
                    end
                end
                RD_DATA, ID_DATA: begin
                    if (sclk_rise) exact_d = 1'b0;
                    if (sclk_fall) begin
                        oe_d  = 1'b1;
                        bit_d = bit_q + 3'd1;
                        // byte boundary: take the prefetched byte and fetch the next address
                        if (state_q == RD_DATA && bit_q == 3'd0) begin
                            miso_d = buf_q[7];
                            tx_d   = {buf_q[6:0], 17'd0};
                            addr_d = addr_q + ADDR_W'(1);
                            re_d   = 1'b1;
                        end else begin
                            miso_d = tx_q[23];
                            tx_d   = {tx_q[22:0], 1'b0};
                        end
                    end
                end
                WR_DATA: if (sclk_rise) begin
                    exact_d = 1'b0;
                    rx_d    = rx_next;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        we_d    = 1'b1;
                        wdata_d = rx_next;
                    end
                end
                default: if (sclk_rise) exact_d = 1'b0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= 3'd0;
            addr_cnt_q <= 5'd0;
            rx_q       <= 8'd0;
            op_q       <= 8'd0;
            buf_q      <= 8'd0;
            wdata_q    <= 8'd0;
            addr_sh_q  <= '0;
            addr_q     <= '0;
            tx_q       <= 24'd0;
            is_wr_q    <= 1'b0;
            exact_q    <= 1'b0;
            arm_q      <= 1'b0;
            init_q     <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_vld_q   <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            addr_cnt_q <= addr_cnt_d;
            rx_q       <= rx_d;
            op_q       <= op_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            addr_sh_q  <= addr_sh_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            is_wr_q    <= is_wr_d;
            exact_q    <= exact_d;
            arm_q      <= arm_d;
            init_q     <= init_d;
            re_q       <= re_d;
            we_q       <= we_d;
            rd_vld_q   <= rd_vld_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
        end
    end
    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_re      = re_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;
    assign init_done   = init_q;
    assign cmd_err     = err_q;
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed SPI transactions against a bench-side byte RAM
module tb_spi_mem_responder;
    import spi_mem_pkg::*;
    localparam int HALF = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_re, mem_we, init_done, cmd_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, mem_wdata;
    logic [7:0]  ram [0:65535];
    logic [15:0] we_addr [0:15];
    logic [7:0]  we_data [0:15];
    int          we_cnt = 0, re_cnt = 0, err_cnt = 0, oe_cnt = 0;
    logic        preload = 1'b0;
    int          n_cmp = 0, n_fail = 0;
    spi_mem_responder #(.ADDR_W(16), .DEVICE_ID(24'h0D5D52), .REQUIRE_INIT(1'b1)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .init_done(init_done), .cmd_err(cmd_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (preload) begin
            ram[16'hFFFF] <= 8'h3C;
            ram[16'h0000] <= 8'h81;
        end
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_addr[we_cnt[3:0]] <= mem_addr;
            we_data[we_cnt[3:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
            re_cnt <= re_cnt + 1;
        end
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
    end
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            rx[i] = spi_miso;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask
    task automatic send(input logic [7:0] b);
        logic [7:0] d;
        xfer(b, 8, d);
    endtask
    task automatic cs_on;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask
    task automatic cs_off;
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask
    task automatic one_byte_txn(input logic [7:0] op);
        cs_on;
        send(op);
        cs_off;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({spi_miso, spi_miso_oe} !== 2'b00) begin n_fail++; $display("FAIL reset_miso: got %b want 00", {spi_miso, spi_miso_oe}); end
        n_cmp++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_re, mem_we}); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
        n_cmp++; if ({init_done, cmd_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {init_done, cmd_err}); end
    endtask
    task automatic test_write_locked;
        int we0 = we_cnt;
        int err0 = err_cnt;
        logic [7:0] old = ram[16'h0010];
        cs_on;
        send(OP_WRITE); send(8'h00); send(8'h00); send(8'h10); send(8'hA5);
        cs_off;
        n_cmp++; if (we_cnt !== we0) begin n_fail++; $display("FAIL locked_we: got %0d writes want 0", we_cnt - we0); end
        n_cmp++; if (ram[16'h0010] !== old) begin n_fail++; $display("FAIL locked_ram: got %h want %h", ram[16'h0010], old); end
        n_cmp++; if (err_cnt !== err0) begin n_fail++; $display("FAIL locked_err: got %0d pulses want 0", err_cnt - err0); end
    endtask
    task automatic test_init;
        one_byte_txn(OP_RSTEN);
        cs_on;
        send(OP_RST);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_early: got %b want 0", init_done); end
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_rise: got %b want 1", init_done); end
        repeat (40) @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_sticky: got %b want 1", init_done); end
    endtask
    task automatic test_write;
        logic [7:0] exp [0:2] = '{8'hA5, 8'h5A, 8'hC3};
        int we0 = we_cnt;
        cs_on;
        send(OP_WRITE); send(8'h00); send(8'h00); send(8'h10);
        for (int i = 0; i < 3; i++) send(exp[i]);
        cs_off;
        n_cmp++; if (we_cnt - we0 !== 3) begin n_fail++; $display("FAIL write_count: got %0d want 3", we_cnt - we0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (we_addr[we0 + i] !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL write_addr%0d: got %h want %h", i, we_addr[we0 + i], 16'h0010 + 16'(i)); end
            n_cmp++; if (we_data[we0 + i] !== exp[i]) begin n_fail++; $display("FAIL write_data%0d: got %h want %h", i, we_data[we0 + i], exp[i]); end
        end
    endtask
    task automatic test_read;
        logic [7:0] exp [0:2] = '{8'hA5, 8'h5A, 8'hC3};
        logic [7:0] d;
        cs_on;
        send(OP_READ); send(8'h00); send(8'h00);
        n_cmp++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_addr: got %b want 0", spi_miso_oe); end
        send(8'h10);
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, 8, d);
            n_cmp++; if (d !== exp[i]) begin n_fail++; $display("FAIL read_byte%0d: got %h want %h", i, d, exp[i]); end
        end
        n_cmp++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe_data: got %b want 1", spi_miso_oe); end
        cs_off;
        n_cmp++; if ({spi_miso_oe, spi_miso} !== 2'b00) begin n_fail++; $display("FAIL read_oe_end: got %b want 00", {spi_miso_oe, spi_miso}); end
    endtask
    task automatic test_wrap;
        logic [7:0] d0, d1;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        cs_on;
        send(OP_READ); send(8'h00); send(8'hFF); send(8'hFF);
        xfer(8'h00, 8, d0);
        xfer(8'h00, 8, d1);
        cs_off;
        n_cmp++; if (d0 !== 8'h3C) begin n_fail++; $display("FAIL wrap_byte0: got %h want 3c", d0); end
        n_cmp++; if (d1 !== 8'h81) begin n_fail++; $display("FAIL wrap_byte1: got %h want 81", d1); end
    endtask
    task automatic test_read_id;
        logic [7:0] exp [0:3] = '{8'h0D, 8'h5D, 8'h52, 8'h00};
        logic [7:0] d;
        int re0 = re_cnt;
        cs_on;
        send(OP_RDID);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 8, d);
            n_cmp++; if (d !== exp[i]) begin n_fail++; $display("FAIL id_byte%0d: got %h want %h", i, d, exp[i]); end
        end
        cs_off;
        n_cmp++; if (re_cnt !== re0) begin n_fail++; $display("FAIL id_no_re: got %0d reads want 0", re_cnt - re0); end
    endtask
    task automatic test_bad_opcode;
        int err0 = err_cnt;
        int oe0 = oe_cnt;
        cs_on;
        send(8'hAB); send(8'h00);
        cs_off;
        n_cmp++; if (err_cnt - err0 !== 1) begin n_fail++; $display("FAIL bad_err: got %0d pulses want 1", err_cnt - err0); end
        n_cmp++; if (oe_cnt !== oe0) begin n_fail++; $display("FAIL bad_oe: got %0d oe cycles want 0", oe_cnt - oe0); end
    endtask
    task automatic test_partial_and_reinit;
        logic [7:0] d;
        int we0 = we_cnt;
        cs_on;
        send(OP_WRITE); send(8'h00); send(8'h00); send(8'h20);
        xfer(8'hFF, 5, d);
        cs_off;
        n_cmp++; if (we_cnt !== we0) begin n_fail++; $display("FAIL partial_we: got %0d writes want 0", we_cnt - we0); end
        cs_on;
        send(OP_READ);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL midrst_init: got %b want 0", init_done); end
        send(OP_RSTEN);
        cs_off;
        one_byte_txn(OP_RST);
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL midrst_arm: got %b want 0", init_done); end
        one_byte_txn(OP_RSTEN);
        one_byte_txn(8'h05);
        one_byte_txn(OP_RST);
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL interrupted_seq: got %b want 0", init_done); end
        one_byte_txn(OP_RSTEN);
        one_byte_txn(OP_RST);
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reinit: got %b want 1", init_done); end
    endtask
    initial begin
        test_reset;
        test_write_locked;
        test_init;
        test_write;
        test_read;
        test_wrap;
        test_read_id;
        test_bad_opcode;
        test_partial_and_reinit;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
